bitcoin_nonce_search: RTL and testbench
=======================================

// Module: bitcoin_nonce_search
// PURPOSE
//  Parametrised successor to the fixed 16-nonce bitcoin hasher. Reads a 20-word block header from memory once.
//  Computes the phase-1 midstate once, then double-SHA256 for NUM_NONCES nonces starting at nonce_base.
//  Writes each digest word H0 to memory and compares it against a difficulty target, with optional early exit.
//  Sits on the shared single-port word memory alongside the other hash engines.
// PARAMETERS
//  NUM_NONCES     16  nonces searched per start, 1..65536
//  STOP_ON_MATCH  0   1: terminate after the first H0 < target; 0: scan all nonces and latch the first match
//  ADDR_W         16  memory address width
// PORTS
//  clk            in   1       system clock; mem_clk = clk
//  reset_n        in   1       asynchronous, active-low reset
//  start          in   1       sampled in IDLE only; ignored while busy
//  message_addr   in   ADDR_W  base of the 20-word header (words 0..18 used; word 19 is replaced by the nonce)
//  output_addr    in   ADDR_W  base of the H0 result array
//  nonce_base     in   32      first nonce; sampled with start
//  target         in   32      match when H0 < target (unsigned); sampled with start
//  done           out  1       high in IDLE; low from the cycle after start until the job ends
//  found          out  1       a match occurred in the current/last job
//  found_nonce    out  32      nonce of the first match
//  found_h0       out  32      H0 of the first match
//  mem_clk        out  1       = clk
//  mem_we         out  1       write strobe
//  mem_addr       out  ADDR_W  registered address
//  mem_write_data out  32      registered write data
//  mem_read_data  in   32      valid 2 edges after mem_addr is registered
// BEHAVIOUR
//  Reset values: done=1, found=0, found_nonce=0, found_h0=0, mem_we=0, mem_addr=0, mem_write_data=0; FSM=IDLE.
//  FSM transitions:
//   IDLE  -> RD     on start; latch inputs, clear found, i=0.
//   RD    : stream reads of words 0..18, one address per cycle, pipelined; buffer words 16..18.
//           Issue words 0..15 to the core as block 1 with IV.
//   MID   : wait core done; midstate = IV + result (32-bit wrap adds).
//   B2    : block = {w16, w17, w18, nonce, 0x80000000, 10x0, 640}; chain = midstate.
//   B3    : block = {digest[0..7], 0x80000000, 6x0, 256}; chain = IV.
//   WR    : 1 cycle: mem_we=1, mem_addr = output_addr + i, data = H0. Compare H0 < target.
//           On first match: found=1, found_nonce, found_h0 latched.
//   NEXT  : i+1. If STOP_ON_MATCH && matched, or i+1 == NUM_NONCES -> IDLE (done=1, mem_we=0).
//           Otherwise -> B2 with nonce+1.
//  Arithmetic: nonce = nonce_base + i, modulo 2^32 (0xFFFFFFFF wraps to 0).
//   Address adds wrap modulo 2^ADDR_W. All SHA adds are mod 2^32.
//  mem_we is high for exactly one cycle per written nonce; it is never high during reads.
//  Output array entries at or beyond the early-exit point are left unwritten.
//  Latency: core 66 cycles/block (1 load + 64 rounds + 1 add). Job ~= 22 + 66 + NUM_NONCES*(2*66+2) cycles.
//  start held high at job end: a new job begins the cycle after done rises. No back-to-back start without IDLE.
//  reset_n low at any time: immediate abort; mem_we drops asynchronously; no partial write completes.
//  found/found_* hold their values until the next accepted start.
// STRUCTURE
//  bitcoin_pkg:
//   - K[0:63] constants, IV[0:7], rrot function
//   - sha256 word-expansion function, pad constants (0x80000000, 640, 256)
//   - state enum
//  Sub-module sha256_core handles one 512-bit compression.
//   - Ports: clk, reset_n, start, chain_in[8], block_in[16], done, digest_out[8].
//   - 16-word rolling W window; one round per cycle; digest = chain + working vars.
//  Top level owns the FSM, the memory port, the nonce counter and the compare.
// TESTING
//  Ref model: Python double-SHA256 of header words 0..18 + nonce, big-endian words. All H0 are compared bit-exact.
//  1 Header 0x01234567 + 0x11111111*k, nonce_base=0, target=0, NUM_NONCES=16.
//    -> 16 writes at output_addr..+15 equal the model; found=0.
//  2 Same header, target=0xFFFFFFFF, STOP_ON_MATCH=1, nonce_base=5.
//    -> exactly one write; found=1, found_nonce=5, found_h0 = model H0(5).
//  3 nonce_base=0xFFFFFFFE, NUM_NONCES=4.
//    -> nonces FFFFFFFE, FFFFFFFF, 0, 1 are used; 4 writes match the model.
//  4 STOP_ON_MATCH=0, target = model H0(nonce 7)+1, chosen so no earlier nonce matches.
//    -> all 16 writes; found_nonce=7.
//  5 reset_n pulsed low mid-B2 of nonce 3.
//    -> mem_we=0 at once; done=1, found=0; a restart reproduces scenario 1 exactly.
//  6 start pulsed while busy, and NUM_NONCES=1.
//    -> the busy start is ignored; the NUM_NONCES=1 job produces 1 write, then done=1.

Source files
------------

// File: rtl/bitcoin_pkg.sv
// rtl/bitcoin_pkg.sv - shared SHA-256 constants, helpers and state types for the nonce search engine
package bitcoin_pkg;

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] IV [0:7] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  // Padding words: leading 1 bit, and message bit lengths of the 80-byte header and 32-byte digest
  localparam logic [31:0] PAD_WORD = 32'h8000_0000;
  localparam logic [31:0] LEN_640  = 32'd640;
  localparam logic [31:0] LEN_256  = 32'd256;

  typedef enum logic [2:0] {S_IDLE, S_RD, S_MID, S_B2, S_B3, S_WR, S_NEXT} state_t;
  typedef enum logic [1:0] {C_IDLE, C_RUN, C_ADD} core_state_t;

  function automatic logic [31:0] rrot(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rrot(x, 2) ^ rrot(x, 13) ^ rrot(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rrot(x, 6) ^ rrot(x, 11) ^ rrot(x, 25);
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return rrot(x, 7) ^ rrot(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return rrot(x, 17) ^ rrot(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f, input logic [31:0] g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

  // Next schedule word W[t+16] from the window words W[t], W[t+1], W[t+9], W[t+14]
  function automatic logic [31:0] sha_expand(input logic [31:0] w0, input logic [31:0] w1,
                                             input logic [31:0] w9, input logic [31:0] w14);
    return small_sigma1(w14) + w9 + small_sigma0(w1) + w0;
  endfunction

endpackage

// File: rtl/sha256_core.sv
// rtl/sha256_core.sv - one SHA-256 compression: load, 64 rounds, chain add (66 cycles)
module sha256_core
  import bitcoin_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] chain_in   [8],
  input  logic [31:0] block_in   [16],
  output logic        done,
  output logic [31:0] digest_out [8]
);

  core_state_t cst_q, cst_d;
  logic [5:0]  round_q, round_d;
  logic [31:0] chain_q [8];
  logic [31:0] chain_d [8];
  logic [31:0] var_q [8];
  logic [31:0] var_d [8];
  logic [31:0] w_q [16];
  logic [31:0] w_d [16];
  logic [31:0] digest_q [8];
  logic [31:0] digest_d [8];
  logic        done_q, done_d;
  logic [31:0] t1, t2;

  // Round datapath and sequencing; w_q[0] always holds the schedule word for the current round
  always_comb begin
    cst_d    = cst_q;
    round_d  = round_q;
    chain_d  = chain_q;
    var_d    = var_q;
    w_d      = w_q;
    digest_d = digest_q;
    done_d   = 1'b0;
    t1 = var_q[7] + big_sigma1(var_q[4]) + ch(var_q[4], var_q[5], var_q[6]) + K[round_q] + w_q[0];
    t2 = big_sigma0(var_q[0]) + maj(var_q[0], var_q[1], var_q[2]);
    case (cst_q)
      C_IDLE: begin
        if (start) begin
          chain_d = chain_in;
          var_d   = chain_in;
          w_d     = block_in;
          round_d = 6'd0;
          cst_d   = C_RUN;
        end
      end
      C_RUN: begin
        var_d[0] = t1 + t2;
        var_d[1] = var_q[0];
        var_d[2] = var_q[1];
        var_d[3] = var_q[2];
        var_d[4] = var_q[3] + t1;
        var_d[5] = var_q[4];
        var_d[6] = var_q[5];
        var_d[7] = var_q[6];
        for (int j = 0; j < 15; j++) w_d[j] = w_q[j+1];
        w_d[15] = sha_expand(w_q[0], w_q[1], w_q[9], w_q[14]);
        round_d = round_q + 6'd1;
        if (round_q == 6'd63) cst_d = C_ADD;
      end
      C_ADD: begin
        for (int j = 0; j < 8; j++) digest_d[j] = chain_q[j] + var_q[j];
        done_d = 1'b1;
        cst_d  = C_IDLE;
      end
      default: cst_d = C_IDLE;
    endcase
  end

  // State registers; digest is held until the next compression finishes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cst_q   <= C_IDLE;
      round_q <= 6'd0;
      done_q  <= 1'b0;
      for (int j = 0; j < 8; j++) begin
        chain_q[j]  <= '0;
        var_q[j]    <= '0;
        digest_q[j] <= '0;
      end
      for (int j = 0; j < 16; j++) w_q[j] <= '0;
    end else begin
      cst_q    <= cst_d;
      round_q  <= round_d;
      done_q   <= done_d;
      chain_q  <= chain_d;
      var_q    <= var_d;
      digest_q <= digest_d;
      w_q      <= w_d;
    end
  end

  assign done       = done_q;
  assign digest_out = digest_q;

endmodule

// File: rtl/bitcoin_nonce_search.sv
// rtl/bitcoin_nonce_search.sv - header fetch, midstate, per-nonce double SHA-256, H0 write-back and target compare
module bitcoin_nonce_search
  import bitcoin_pkg::*;
#(
  parameter int NUM_NONCES    = 16,
  parameter bit STOP_ON_MATCH = 1'b0,
  parameter int ADDR_W        = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] message_addr,
  input  logic [ADDR_W-1:0] output_addr,
  input  logic [31:0]       nonce_base,
  input  logic [31:0]       target,
  output logic              done,
  output logic              found,
  output logic [31:0]       found_nonce,
  output logic [31:0]       found_h0,
  output logic              mem_clk,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_write_data,
  input  logic [31:0]       mem_read_data
);

  state_t            state_q, state_d;
  logic [4:0]        rd_cnt_q, rd_cnt_d;
  logic [31:0]       hdr_q [0:18];
  logic [31:0]       hdr_d [0:18];
  logic [ADDR_W-1:0] msg_addr_q, msg_addr_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic [31:0]       nonce_q, nonce_d;
  logic [31:0]       target_q, target_d;
  logic [16:0]       idx_q, idx_d;
  logic [31:0]       mid_q [8];
  logic [31:0]       mid_d [8];
  logic [31:0]       h0_q, h0_d;
  logic              core_start_q, core_start_d;
  logic              done_q, done_d;
  logic              found_q, found_d;
  logic [31:0]       found_nonce_q, found_nonce_d;
  logic [31:0]       found_h0_q, found_h0_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;

  logic [31:0] core_chain  [8];
  logic [31:0] core_block  [16];
  logic [31:0] core_digest [8];
  logic        core_done;

  // Core operand select: block 1 of the header, block 2 with the nonce, or the second hash over the digest
  always_comb begin
    for (int j = 0; j < 8; j++) core_chain[j] = IV[j];
    for (int j = 0; j < 16; j++) core_block[j] = '0;
    case (state_q)
      S_RD, S_MID: begin
        for (int j = 0; j < 16; j++) core_block[j] = hdr_q[j];
      end
      S_B2: begin
        core_chain     = mid_q;
        core_block[0]  = hdr_q[16];
        core_block[1]  = hdr_q[17];
        core_block[2]  = hdr_q[18];
        core_block[3]  = nonce_q;
        core_block[4]  = PAD_WORD;
        core_block[15] = LEN_640;
      end
      default: begin
        for (int j = 0; j < 8; j++) core_block[j] = core_digest[j];
        core_block[8]  = PAD_WORD;
        core_block[15] = LEN_256;
      end
    endcase
  end

  sha256_core u_core (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (core_start_q),
    .chain_in   (core_chain),
    .block_in   (core_block),
    .done       (core_done),
    .digest_out (core_digest)
  );

  // Job sequencing: header fetch, midstate, per-nonce hashing, write-back and compare
  always_comb begin
    state_d       = state_q;
    rd_cnt_d      = rd_cnt_q;
    hdr_d         = hdr_q;
    msg_addr_d    = msg_addr_q;
    out_addr_d    = out_addr_q;
    nonce_d       = nonce_q;
    target_d      = target_q;
    idx_d         = idx_q;
    mid_d         = mid_q;
    h0_d          = h0_q;
    core_start_d  = 1'b0;
    done_d        = done_q;
    found_d       = found_q;
    found_nonce_d = found_nonce_q;
    found_h0_d    = found_h0_q;
    mem_we_d      = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    case (state_q)
      S_IDLE: begin
        done_d = 1'b1;
        if (start) begin
          msg_addr_d    = message_addr;
          out_addr_d    = output_addr;
          nonce_d       = nonce_base;
          target_d      = target;
          found_d       = 1'b0;
          found_nonce_d = '0;
          found_h0_d    = '0;
          idx_d         = '0;
          rd_cnt_d      = '0;
          done_d        = 1'b0;
          state_d       = S_RD;
        end
      end
      S_RD: begin
        // Address k goes out on count k; its data is captured two counts later
        if (rd_cnt_q <= 5'd18) mem_addr_d = msg_addr_q + ADDR_W'(rd_cnt_q);
        if (rd_cnt_q >= 5'd2) hdr_d[rd_cnt_q - 5'd2] = mem_read_data;
        rd_cnt_d = rd_cnt_q + 5'd1;
        if (rd_cnt_q == 5'd20) begin
          core_start_d = 1'b1;
          state_d      = S_MID;
        end
      end
      S_MID: begin
        if (core_done) begin
          mid_d        = core_digest;
          core_start_d = 1'b1;
          state_d      = S_B2;
        end
      end
      S_B2: begin
        if (core_done) begin
          core_start_d = 1'b1;
          state_d      = S_B3;
        end
      end
      S_B3: begin
        if (core_done) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = out_addr_q + ADDR_W'(idx_q);
          mem_wdata_d = core_digest[0];
          h0_d        = core_digest[0];
          state_d     = S_WR;
        end
      end
      S_WR: begin
        if (!found_q && (h0_q < target_q)) begin
          found_d       = 1'b1;
          found_nonce_d = nonce_q;
          found_h0_d    = h0_q;
        end
        state_d = S_NEXT;
      end
      S_NEXT: begin
        idx_d   = idx_q + 17'd1;
        nonce_d = nonce_q + 32'd1;
        if ((STOP_ON_MATCH && found_q) || ((idx_q + 17'd1) == 17'(NUM_NONCES))) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          core_start_d = 1'b1;
          state_d      = S_B2;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // All job state and registered outputs; reset aborts any job and drops mem_we immediately
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      rd_cnt_q      <= '0;
      msg_addr_q    <= '0;
      out_addr_q    <= '0;
      nonce_q       <= '0;
      target_q      <= '0;
      idx_q         <= '0;
      h0_q          <= '0;
      core_start_q  <= 1'b0;
      done_q        <= 1'b1;
      found_q       <= 1'b0;
      found_nonce_q <= '0;
      found_h0_q    <= '0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      for (int j = 0; j < 19; j++) hdr_q[j] <= '0;
      for (int j = 0; j < 8; j++) mid_q[j] <= '0;
    end else begin
      state_q       <= state_d;
      rd_cnt_q      <= rd_cnt_d;
      msg_addr_q    <= msg_addr_d;
      out_addr_q    <= out_addr_d;
      nonce_q       <= nonce_d;
      target_q      <= target_d;
      idx_q         <= idx_d;
      h0_q          <= h0_d;
      core_start_q  <= core_start_d;
      done_q        <= done_d;
      found_q       <= found_d;
      found_nonce_q <= found_nonce_d;
      found_h0_q    <= found_h0_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      hdr_q         <= hdr_d;
      mid_q         <= mid_d;
    end
  end

  assign done           = done_q;
  assign found          = found_q;
  assign found_nonce    = found_nonce_q;
  assign found_h0       = found_h0_q;
  assign mem_clk        = clk;
  assign mem_we         = mem_we_q;
  assign mem_addr       = mem_addr_q;
  assign mem_write_data = mem_wdata_q;

endmodule

// File: tb/tb_bitcoin_nonce_search.sv
// tb/tb_bitcoin_nonce_search.sv - bench for bitcoin_nonce_search against a double-SHA256 reference model
module tb_bitcoin_nonce_search;

  typedef logic [31:0] w8_t [8];
  typedef logic [31:0] w16_t [16];

  localparam logic [15:0] MSG_ADDR = 16'h0010;

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [31:0] IVT [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  start_v, clr_log;
  logic [15:0] message_addr, output_addr;
  logic [31:0] nonce_base, target;
  logic [3:0]  done_v, found_v, mem_clk_v, mem_we_v;
  logic [31:0] found_nonce_v [4];
  logic [31:0] found_h0_v [4];
  logic [31:0] wdata_v [4];
  logic [31:0] rdata_v [4];
  logic [15:0] addr_v [4];
  logic [31:0] hdr [19];
  logic [15:0] log_addr [4][32];
  logic [31:0] log_data [4][32];
  int          wr_cnt [4];
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  // Four engines: 16 nonces scan-all, 16 nonces stop-on-match, 4 nonces, 1 nonce
  for (genvar g = 0; g < 4; g++) begin : g_dut
    bitcoin_nonce_search #(
      .NUM_NONCES    (g == 2 ? 4 : (g == 3 ? 1 : 16)),
      .STOP_ON_MATCH (g == 1 ? 1'b1 : 1'b0),
      .ADDR_W        (16)
    ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .start          (start_v[g]),
      .message_addr   (message_addr),
      .output_addr    (output_addr),
      .nonce_base     (nonce_base),
      .target         (target),
      .done           (done_v[g]),
      .found          (found_v[g]),
      .found_nonce    (found_nonce_v[g]),
      .found_h0       (found_h0_v[g]),
      .mem_clk        (mem_clk_v[g]),
      .mem_we         (mem_we_v[g]),
      .mem_addr       (addr_v[g]),
      .mem_write_data (wdata_v[g]),
      .mem_read_data  (rdata_v[g])
    );

    always @(posedge clk) begin
      if ((addr_v[g] - MSG_ADDR) < 16'd19) rdata_v[g] <= hdr[5'(addr_v[g] - MSG_ADDR)];
      else rdata_v[g] <= 32'hDEAD_BEEF;
    end

    always @(posedge clk) begin
      if (clr_log[g]) wr_cnt[g] <= 0;
      else if (mem_we_v[g]) begin
        if (wr_cnt[g] < 32) begin
          log_addr[g][5'(wr_cnt[g])] <= addr_v[g];
          log_data[g][5'(wr_cnt[g])] <= wdata_v[g];
        end
        wr_cnt[g] <= wr_cnt[g] + 1;
      end
    end
  end

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic w8_t compress(input w8_t hin, input w16_t m);
    logic [31:0] w [64];
    w8_t v, r;
    logic [31:0] t1, t2, s0, s1;
    for (int t = 0; t < 16; t++) w[t] = m[t];
    for (int t = 16; t < 64; t++) begin
      s0 = ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = s1 + w[t-7] + s0 + w[t-16];
    end
    v = hin;
    for (int t = 0; t < 64; t++) begin
      t1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
      t2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
      v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
    end
    for (int j = 0; j < 8; j++) r[j] = hin[j] + v[j];
    return r;
  endfunction

  // Bitcoin double SHA-256 of the 80-byte header (words 0..18 plus nonce); returns H0 of the outer hash
  function automatic logic [31:0] model_h0(input logic [31:0] nonce);
    w16_t b;
    w8_t iv, mid, d1, d2;
    for (int j = 0; j < 8; j++) iv[j] = IVT[j];
    for (int j = 0; j < 16; j++) b[j] = hdr[j];
    mid = compress(iv, b);
    for (int j = 0; j < 16; j++) b[j] = 32'h0;
    b[0] = hdr[16]; b[1] = hdr[17]; b[2] = hdr[18]; b[3] = nonce;
    b[4] = 32'h8000_0000; b[15] = 32'd640;
    d1 = compress(mid, b);
    for (int j = 0; j < 16; j++) b[j] = 32'h0;
    for (int j = 0; j < 8; j++) b[j] = d1[j];
    b[8] = 32'h8000_0000; b[15] = 32'd256;
    d2 = compress(iv, b);
    return d2[0];
  endfunction

  function automatic int nn_of(input int g);
    return (g == 2) ? 4 : ((g == 3) ? 1 : 16);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input int g, input int budget, input string tag);
    int n = 0;
    while (done_v[g] !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done_in_time"}, {63'd0, done_v[g]}, 64'd1);
  endtask

  task automatic check_job(input int g, input logic [31:0] nb, input logic [31:0] tgt,
                           input logic [15:0] oaddr, input string tag);
    logic [31:0] h0s [$];
    logic [31:0] h;
    int m = -1;
    int nn = nn_of(g);
    int nw;
    for (int i = 0; i < nn; i++) begin
      h = model_h0(nb + 32'(i));
      h0s.push_back(h);
      if (m < 0 && h < tgt) m = i;
    end
    nw = (g == 1 && m >= 0) ? m + 1 : nn;
    chk({tag, "_write_count"}, 64'(wr_cnt[g]), 64'(nw));
    for (int i = 0; i < nw && i < 32; i++) begin
      chk($sformatf("%s_addr%0d", tag, i), {48'd0, log_addr[g][i]}, {48'd0, oaddr + 16'(i)});
      chk($sformatf("%s_h0_%0d", tag, i), {32'd0, log_data[g][i]}, {32'd0, h0s[i]});
    end
    chk({tag, "_found"}, {63'd0, found_v[g]}, {63'd0, (m >= 0)});
    if (m >= 0) begin
      chk({tag, "_found_nonce"}, {32'd0, found_nonce_v[g]}, {32'd0, nb + 32'(m)});
      chk({tag, "_found_h0"}, {32'd0, found_h0_v[g]}, {32'd0, h0s[m]});
    end
  endtask

  task automatic launch(input int g, input logic [31:0] nb, input logic [31:0] tgt,
                        input logic [15:0] oaddr, input string tag);
    message_addr = MSG_ADDR;
    output_addr  = oaddr;
    nonce_base   = nb;
    target       = tgt;
    start_v[g]   = 1'b1;
    clr_log[g]   = 1'b1;
    @(negedge clk);
    start_v[g]   = 1'b0;
    clr_log[g]   = 1'b0;
    chk({tag, "_busy"}, {63'd0, done_v[g]}, 64'd0);
  endtask

  task automatic run_job(input int g, input logic [31:0] nb, input logic [31:0] tgt,
                         input logic [15:0] oaddr, input string tag);
    launch(g, nb, tgt, oaddr, tag);
    wait_done(g, 6000, tag);
    check_job(g, nb, tgt, oaddr, tag);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    w16_t ab;
    w8_t iv, dab;
    logic [31:0] s4_base, s4_h7, mn, hv;
    logic [31:0] rb, rt;
    bit ok;
    int n;

    reset_n = 1'b0;
    start_v = '0;
    clr_log = '0;
    message_addr = '0;
    output_addr = '0;
    nonce_base = '0;
    target = '0;
    for (int k = 0; k < 19; k++) hdr[k] = 32'h0123_4567 + 32'h1111_1111 * 32'(k);

    // Reference model sanity: SHA-256("abc")
    for (int j = 0; j < 8; j++) iv[j] = IVT[j];
    for (int j = 0; j < 16; j++) ab[j] = 32'h0;
    ab[0] = 32'h6162_6380;
    ab[15] = 32'h18;
    dab = compress(iv, ab);
    chk("model_abc", {32'd0, dab[0]}, {32'd0, 32'hba78_16bf});

    repeat (3) @(negedge clk);
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("reset_done%0d", g), {63'd0, done_v[g]}, 64'd1);
      chk($sformatf("reset_we%0d", g), {63'd0, mem_we_v[g]}, 64'd0);
    end
    chk("reset_found", {63'd0, found_v[0]}, 64'd0);
    chk("reset_found_nonce", {32'd0, found_nonce_v[0]}, 64'd0);
    chk("reset_found_h0", {32'd0, found_h0_v[0]}, 64'd0);
    chk("reset_addr", {48'd0, addr_v[0]}, 64'd0);
    chk("reset_wdata", {32'd0, wdata_v[0]}, 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    run_job(0, 32'h0, 32'h0, 16'h0040, "s1");
    run_job(1, 32'd5, 32'hFFFF_FFFF, 16'h0040, "s2");
    run_job(2, 32'hFFFF_FFFE, 32'h0, 16'h0040, "s3");

    // Pick a base whose 8th nonce beats the seven before it, so the first match lands there
    s4_base = 32'h0;
    s4_h7 = 32'h0;
    ok = 1'b0;
    for (int b = 0; b < 128 && !ok; b++) begin
      mn = 32'hFFFF_FFFF;
      for (int i = 0; i < 7; i++) begin
        hv = model_h0(32'(b) + 32'(i));
        if (hv < mn) mn = hv;
      end
      hv = model_h0(32'(b) + 32'd7);
      if (hv < mn) begin
        ok = 1'b1;
        s4_base = 32'(b);
        s4_h7 = hv;
      end
    end
    run_job(0, s4_base, s4_h7 + 32'd1, 16'h0060, "s4");
    chk("s4_nonce7", {32'd0, found_nonce_v[0]}, {32'd0, s4_base + 32'd7});

    // Abort in the middle of the fourth nonce's second block
    launch(0, 32'h0, 32'hFFFF_FFFF, 16'h0040, "s5");
    n = 0;
    while (wr_cnt[0] < 3 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("s5_reached_nonce3", 64'(wr_cnt[0]), 64'd3);
    repeat (30) @(negedge clk);
    chk("s5_found_before_reset", {63'd0, found_v[0]}, 64'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("s5_we_at_reset", {63'd0, mem_we_v[0]}, 64'd0);
    chk("s5_done_at_reset", {63'd0, done_v[0]}, 64'd1);
    chk("s5_found_at_reset", {63'd0, found_v[0]}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (200) @(negedge clk);
    chk("s5_no_more_writes", 64'(wr_cnt[0]), 64'd3);
    run_job(0, 32'h0, 32'h0, 16'h0040, "s5_restart");

    // Start pulsed during a busy single-nonce job must be ignored
    launch(3, 32'h0000_1234, 32'h0, 16'h0040, "s6");
    repeat (10) @(negedge clk);
    nonce_base = 32'h0000_9999;
    start_v[3] = 1'b1;
    @(negedge clk);
    start_v[3] = 1'b0;
    wait_done(3, 1000, "s6");
    check_job(3, 32'h0000_1234, 32'h0, 16'h0040, "s6");
    repeat (300) @(negedge clk);
    chk("s6_idle_after", {63'd0, done_v[3]}, 64'd1);
    chk("s6_single_write", 64'(wr_cnt[3]), 64'd1);

    // Random header, nonce base and target
    for (int k = 0; k < 19; k++) hdr[k] = $urandom();
    rb = $urandom();
    rt = $urandom();
    run_job(0, rb, rt, 16'h0080, "rnd_scan");
    rb = $urandom();
    rt = $urandom();
    run_job(1, rb, rt, 16'h00A0, "rnd_stop");
    rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 2));
    run_job(2, rb, 32'h4000_0000, 16'h00C0, "rnd_wrap");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
